// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the two-port data memory arbiter.
package dmem_arb_pkg;

   localparam int NUM_PORTS = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

   // Port 0 takes the first contention after reset.
   localparam logic LAST_RST = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory side signals of the data memory arbiter.
interface dmem_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
) ();

   logic              req0;
   logic              req1;
   logic              we0;
   logic              we1;
   logic [ADDR_W-1:0] addr0;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata0;
   logic [DATA_W-1:0] wdata1;
   logic              ack0;
   logic              ack1;
   logic [DATA_W-1:0] rdata0;
   logic [DATA_W-1:0] rdata1;
   logic              busy;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_we;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1,
      input  wdata0, wdata1, mem_rdata,
      output ack0, ack1, rdata0, rdata1, busy,
      output mem_addr, mem_wdata, mem_we
   );

   modport master (
      output req0, req1, we0, we1, addr0, addr1,
      output wdata0, wdata1, mem_rdata,
      input  ack0, ack1, rdata0, rdata1, busy,
      input  mem_addr, mem_wdata, mem_we
   );

endinterface

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-input round-robin picker; on contention the port not granted last wins.
module rr_pick2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic       valid,
   output logic       id
);

   assign valid = |req;
   assign id    = (&req) ? ~last : req[1];

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing storage_mem between two requesters.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
) (
   input logic           clk,
   input logic           rst,
   dmem_arbiter_if.slave bus
);

   state_t               r_state;
   state_t               w_next;
   logic                 r_last;
   logic                 r_id;
   logic                 r_we;
   logic [ADDR_W-1:0]    r_addr;
   logic [DATA_W-1:0]    r_wdata;
   logic [NUM_PORTS-1:0] r_ack;
   logic [DATA_W-1:0]    r_rdata0;
   logic [DATA_W-1:0]    r_rdata1;
   logic [NUM_PORTS-1:0] w_req;
   logic                 w_valid;
   logic                 w_id;
   logic                 w_busy;
   logic                 w_mem_we;

   // A port acked this cycle is masked so its held request is not re-served.
   assign w_req = {bus.req1 & ~r_ack[1], bus.req0 & ~r_ack[0]};

   rr_pick2 u_pick (
      .req   (w_req),
      .last  (r_last),
      .valid (w_valid),
      .id    (w_id)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE:  if (w_valid) w_next = ST_ISSUE;
         ST_ISSUE: w_next = ST_RESP;
         ST_RESP:  w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      w_busy   = 1'b0;
      w_mem_we = 1'b0;
      unique case (r_state)
         ST_ISSUE: begin
            w_busy   = 1'b1;
            w_mem_we = r_we;
         end
         ST_RESP: w_busy = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last   <= LAST_RST;
         r_id     <= 1'b0;
         r_we     <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_ack    <= '0;
         r_rdata0 <= '0;
         r_rdata1 <= '0;
      end else begin
         r_ack <= '0;
         if (r_state == ST_IDLE && w_valid) begin
            r_id    <= w_id;
            r_we    <= w_id ? bus.we1 : bus.we0;
            r_addr  <= w_id ? bus.addr1 : bus.addr0;
            r_wdata <= w_id ? bus.wdata1 : bus.wdata0;
         end
         if (r_state == ST_RESP) begin
            r_ack[r_id] <= 1'b1;
            r_last      <= r_id;
            if (r_id) r_rdata1 <= bus.mem_rdata;
            else      r_rdata0 <= bus.mem_rdata;
         end
      end
   end

   assign bus.ack0      = r_ack[0];
   assign bus.ack1      = r_ack[1];
   assign bus.rdata0    = r_rdata0;
   assign bus.rdata1    = r_rdata1;
   assign bus.busy      = w_busy;
   assign bus.mem_addr  = r_addr;
   assign bus.mem_wdata = r_wdata;
   assign bus.mem_we    = w_mem_we;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a write-first storage_mem model.
module tb_dmem_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   we_cnt = 0;
   logic [31:0] mem [1024];

   dmem_arbiter_if #(.DATA_W(32), .ADDR_W(32)) bus ();

   dmem_arbiter #(.DATA_W(32), .ADDR_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.mem_we) begin
         mem[bus.mem_addr[11:2]] <= bus.mem_wdata;
         bus.mem_rdata           <= bus.mem_wdata;
      end else begin
         bus.mem_rdata <= mem[bus.mem_addr[11:2]];
      end
   end

   always @(negedge clk) if (bus.mem_we) we_cnt <= we_cnt + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_req(input bit p, input bit we,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output int cyc,
                          output int oth);
      if (p) begin
         bus.we1 = we; bus.addr1 = a; bus.wdata1 = d; bus.req1 = 1'b1;
      end else begin
         bus.we0 = we; bus.addr0 = a; bus.wdata0 = d; bus.req0 = 1'b1;
      end
      cyc = 0;
      oth = 0;
      do begin
         tick();
         cyc++;
         if (p ? bus.ack0 : bus.ack1) oth++;
      end while (!(p ? bus.ack1 : bus.ack0) && cyc < 20);
      rd = p ? bus.rdata1 : bus.rdata0;
      if (p) bus.req1 = 1'b0;
      else   bus.req0 = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if ({bus.ack0, bus.ack1, bus.mem_we, bus.busy} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_ctl got %b want 0000",
                  {bus.ack0, bus.ack1, bus.mem_we, bus.busy});
      end
      checks++;
      if ({bus.rdata0, bus.rdata1} !== 64'h0) begin
         errors++;
         $display("FAIL reset_rdata got %h want 0", {bus.rdata0, bus.rdata1});
      end
      checks++;
      if ({bus.mem_addr, bus.mem_wdata} !== 64'h0) begin
         errors++;
         $display("FAIL reset_mem got %h want 0", {bus.mem_addr, bus.mem_wdata});
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_write_p0();
      logic [31:0] rd;
      int cyc, oth, s;
      s = we_cnt;
      run_req(1'b0, 1'b1, 32'h10, 32'h1234_5678, rd, cyc, oth);
      checks++;
      if (cyc !== 3) begin
         errors++;
         $display("FAIL wr0_latency got %0d want 3", cyc);
      end
      checks++;
      if (rd !== 32'h1234_5678) begin
         errors++;
         $display("FAIL wr0_rdata got %h want 12345678", rd);
      end
      checks++;
      if (we_cnt - s !== 1) begin
         errors++;
         $display("FAIL wr0_we_cycles got %0d want 1", we_cnt - s);
      end
      checks++;
      if ({bus.mem_addr, bus.busy} !== {32'h10, 1'b0}) begin
         errors++;
         $display("FAIL wr0_addr_busy got %h/%b want 10/0", bus.mem_addr, bus.busy);
      end
      tick();
      checks++;
      if ({bus.ack0, bus.rdata0} !== {1'b0, 32'h1234_5678}) begin
         errors++;
         $display("FAIL wr0_ack_pulse got %b/%h want 0/12345678", bus.ack0, bus.rdata0);
      end
   endtask

   task automatic test_read_p1();
      logic [31:0] rd;
      int cyc, oth;
      run_req(1'b1, 1'b0, 32'h10, 32'h0, rd, cyc, oth);
      checks++;
      if (rd !== 32'h1234_5678 || cyc !== 3) begin
         errors++;
         $display("FAIL rd1 got %h in %0d want 12345678 in 3", rd, cyc);
      end
      checks++;
      if (oth !== 0) begin
         errors++;
         $display("FAIL rd1_ack0 got %0d want 0", oth);
      end
   endtask

   task automatic test_contention();
      logic [3:0] ord;
      int n, n0, n1, dbl, last_k, extra;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      bus.we0 = 1'b1; bus.addr0 = 32'h20; bus.wdata0 = 32'hA0A0_0000;
      bus.we1 = 1'b1; bus.addr1 = 32'h24; bus.wdata1 = 32'hB1B1_0001;
      bus.req0 = 1'b1;
      bus.req1 = 1'b1;
      ord = '0; n = 0; n0 = 0; n1 = 0; dbl = 0; last_k = 0; extra = 0;
      for (int k = 1; k <= 30 && n < 4; k++) begin
         tick();
         if (bus.ack0 && bus.ack1) dbl++;
         if (bus.ack0) begin
            ord[3-n] = 1'b0; n++; n0++; last_k = k;
            if (n0 == 2) bus.req0 = 1'b0;
         end
         if (bus.ack1) begin
            ord[3-n] = 1'b1; n++; n1++; last_k = k;
            if (n1 == 2) bus.req1 = 1'b0;
         end
      end
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (bus.ack0 || bus.ack1) extra++;
      end
      checks++;
      if (ord !== 4'b0101 || n !== 4) begin
         errors++;
         $display("FAIL rr_order got %b (%0d) want 0101 (4)", ord, n);
      end
      checks++;
      if (last_k !== 12) begin
         errors++;
         $display("FAIL rr_timing got %0d want 12", last_k);
      end
      checks++;
      if (dbl !== 0 || extra !== 0) begin
         errors++;
         $display("FAIL rr_double got %0d/%0d want 0/0", dbl, extra);
      end
   endtask

   task automatic test_hold_p0();
      int s;
      logic [31:0] hits;
      s = we_cnt;
      hits = '0;
      bus.we0 = 1'b1; bus.addr0 = 32'h30; bus.wdata0 = 32'h0000_0055;
      bus.req0 = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         tick();
         if (bus.ack0) hits[k] = 1'b1;
         if (k == 12) bus.req0 = 1'b0;
      end
      checks++;
      if (hits !== 32'h0000_0888) begin
         errors++;
         $display("FAIL hold_acks got %h want 00000888", hits);
      end
      checks++;
      if (we_cnt - s !== 3) begin
         errors++;
         $display("FAIL hold_accesses got %0d want 3", we_cnt - s);
      end
   endtask

   task automatic test_reset_mid();
      int acks;
      bus.we0 = 1'b1; bus.addr0 = 32'h40; bus.wdata0 = 32'hA5A5_A5A5;
      bus.req0 = 1'b1;
      tick();
      checks++;
      if (bus.mem_we !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_issue got %b want 1", bus.mem_we);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({bus.mem_we, bus.busy} !== 2'b00) begin
         errors++;
         $display("FAIL rstmid_async got %b want 00", {bus.mem_we, bus.busy});
      end
      bus.req0 = 1'b0;
      tick();
      tick();
      checks++;
      if ({bus.ack0, bus.ack1, bus.rdata0, bus.rdata1, bus.mem_addr, bus.mem_wdata}
          !== 130'h0) begin
         errors++;
         $display("FAIL rstmid_values got %h/%h/%h/%h want 0",
                  bus.rdata0, bus.rdata1, bus.mem_addr, bus.mem_wdata);
      end
      rst = 1'b0;
      acks = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (bus.ack0 || bus.ack1 || bus.busy) acks++;
      end
      checks++;
      if (acks !== 0) begin
         errors++;
         $display("FAIL rstmid_noack got %0d want 0", acks);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] rd;
      int cyc, oth;
      run_req(1'b0, 1'b1, 32'h0000_0FFC, 32'hDEAD_BEEF, rd, cyc, oth);
      run_req(1'b0, 1'b1, 32'h0000_1000, 32'h0000_0001, rd, cyc, oth);
      checks++;
      if (bus.mem_addr !== 32'h0000_1000) begin
         errors++;
         $display("FAIL wrap_addr got %h want 00001000", bus.mem_addr);
      end
      run_req(1'b1, 1'b0, 32'h0000_0FFC, 32'h0, rd, cyc, oth);
      checks++;
      if (rd !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL wrap_ffc got %h want deadbeef", rd);
      end
      run_req(1'b1, 1'b0, 32'h0000_0000, 32'h0, rd, cyc, oth);
      checks++;
      if (rd !== 32'h0000_0001) begin
         errors++;
         $display("FAIL wrap_zero got %h want 00000001", rd);
      end
   endtask

   initial begin
      bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
      bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
      test_reset();
      test_write_p0();
      test_read_p1();
      test_contention();
      test_hold_p0();
      test_reset_mid();
      test_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
